wrap_latency_checker: RTL

- Synthesizable RTL monitor for a wrapping cycle counter: start/finish latency checker.
- Latches a cycle timestamp when the monitored count reads 0, then measures elapsed cycles to the first following all-ones count.
- Reports pass or fail against a cycle budget, with an abort input equivalent to disable iff.
- Sits beside the counter block as its silicon-side checker and feeds the debug/status register file.

---
 rtl/wrap_latency_checker_pkg.sv | 18 +
 rtl/wrap_latency_checker_if.sv | 27 ++
 rtl/wrap_latency_checker_sat_counter.sv | 16 +
 rtl/wrap_latency_checker.sv | 112 +++++++++++
 4 files changed

// File: rtl/wrap_latency_checker_pkg.sv
// Shared types, default widths and helpers for the wrapping-counter latency checker.
package wlc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } wlc_state_e;

   localparam int DEF_CNT_W     = 3;
   localparam int DEF_TS_W      = 16;
   localparam int DEF_LIMIT_CYC = 50;
   localparam int DEF_STAT_W    = 8;

   function automatic int unsigned all_ones(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/wrap_latency_checker_if.sv
// Monitor-side bus: the watched count and abort in, verdicts and statistics out.
interface wrap_latency_checker_if
   import wlc_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int TS_W   = DEF_TS_W,
   parameter int STAT_W = DEF_STAT_W
);
   logic [CNT_W-1:0]  count_i;
   logic              disable_i;
   logic              busy_o;
   logic              pass_o;
   logic              fail_o;
   logic [TS_W-1:0]   elapsed_o;
   logic [STAT_W-1:0] pass_cnt_o;
   logic [STAT_W-1:0] fail_cnt_o;

   modport master (
      output count_i, disable_i,
      input  busy_o, pass_o, fail_o, elapsed_o, pass_cnt_o, fail_cnt_o
   );

   modport slave (
      input  count_i, disable_i,
      output busy_o, pass_o, fail_o, elapsed_o, pass_cnt_o, fail_cnt_o
   );
endinterface

// File: rtl/wrap_latency_checker_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (!rst_n)
         q <= '0;
      else if (inc && (q != {W{1'b1}}))
         q <= q + W'(1);
   end
endmodule

// File: rtl/wrap_latency_checker.sv
// Start/finish latency checker: count==0 starts an attempt, all-ones count ends it,
// elapsed cycles are judged against LIMIT_CYC with a free-running timestamp.
//
//   state | meaning
//   IDLE  | no attempt in flight; waiting for count==0 with no abort
//   ARMED | attempt in flight; start timestamp held in start_q
module wrap_latency_checker
   import wlc_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int TS_W      = DEF_TS_W,
   parameter int LIMIT_CYC = DEF_LIMIT_CYC,
   parameter int STAT_W    = DEF_STAT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   wrap_latency_checker_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_ONES = CNT_W'(all_ones(CNT_W));
   localparam logic [TS_W-1:0]  TS_ONES  = '1;
   localparam logic [TS_W-1:0]  LIMIT_TS = TS_W'(LIMIT_CYC);

   if (LIMIT_CYC >= (2 ** TS_W) - 1) begin : g_bad_limit
      $error("LIMIT_CYC must be below the watchdog value 2**TS_W-1");
   end

   wlc_state_e        state_q, state_d;
   logic [TS_W-1:0]   ts_q;
   logic [TS_W-1:0]   start_q, start_d;
   logic [TS_W-1:0]   elapsed_q, elapsed_d;
   logic [TS_W-1:0]   elapsed_now;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic [STAT_W-1:0] pass_cnt, fail_cnt;

   assign elapsed_now = ts_q - start_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ts_q      <= '0;
         start_q   <= '0;
         elapsed_q <= '0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ts_q      <= ts_q + TS_W'(1);
         start_q   <= start_d;
         elapsed_q <= elapsed_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
      end
   end

   // Abort outranks completion, completion outranks re-arm, re-arm outranks watchdog.
   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      elapsed_d = elapsed_q;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if ((bus.count_i == '0) && !bus.disable_i) begin
               start_d = ts_q;
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (bus.disable_i) begin
               state_d = IDLE;
            end else if (bus.count_i == CNT_ONES) begin
               state_d   = IDLE;
               elapsed_d = elapsed_now;
               if (elapsed_now <= LIMIT_TS)
                  pass_d = 1'b1;
               else
                  fail_d = 1'b1;
            end else if (bus.count_i == '0) begin
               start_d = ts_q;
            end else if (elapsed_now == TS_ONES) begin
               state_d   = IDLE;
               elapsed_d = TS_ONES;
               fail_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   sat_counter #(.W(STAT_W)) u_pass_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pass_d),
      .q     (pass_cnt)
   );

   sat_counter #(.W(STAT_W)) u_fail_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (fail_d),
      .q     (fail_cnt)
   );

   assign bus.busy_o     = (state_q == ARMED);
   assign bus.pass_o     = pass_q;
   assign bus.fail_o     = fail_q;
   assign bus.elapsed_o  = elapsed_q;
   assign bus.pass_cnt_o = pass_cnt;
   assign bus.fail_cnt_o = fail_cnt;
endmodule
